uart_tx_byte_feeder: RTL

- Upstream stage of the UART transmit controller.
- Buffers bytes pushed by system logic (message ROM walker, SRAM dump FSM) in a small synchronous FIFO.
- Hands the bytes one at a time to the transmit controller's Start/TX_data/Empty handshake, so producers never poll the serializer.
- Runs fully on Clock; never uses TX_clock_enable.

---
 rtl/uart_tx_byte_feeder_pkg.sv | 13 +
 rtl/uart_tx_sync_fifo.sv | 57 +++++
 rtl/uart_tx_byte_feeder.sv | 93 +++++++++
 3 files changed

// File: rtl/uart_tx_byte_feeder_pkg.sv
// Shared types and constants for the UART transmit byte feeder.
// Feeder state encodings sit beside the TX/RX controller state types.
package uart_tx_byte_feeder_pkg;

    localparam int BYTE_W = 8;

    typedef logic [1:0] tx_feeder_state_t;

    localparam tx_feeder_state_t S_FEED_IDLE = 2'd0;
    localparam tx_feeder_state_t S_FEED_REQ  = 2'd1;
    localparam tx_feeder_state_t S_FEED_WAIT = 2'd2;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Small synchronous byte FIFO with a show-ahead head and a register array.
// Pointers carry one extra MSB so full and empty are distinguishable.
module uart_tx_sync_fifo
    import uart_tx_byte_feeder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Flush,
    input  logic                Push,
    input  logic [BYTE_W-1:0]   Push_data,
    input  logic                Pop,
    output logic [BYTE_W-1:0]   Pop_data,
    output logic                Full,
    output logic                Empty,
    output logic [DEPTH_LOG2:0] Count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [BYTE_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                wr_en;
    logic                rd_en;

    assign Full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2])
                 & (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign Empty = (wr_ptr == rd_ptr);
    assign Count = wr_ptr - rd_ptr;

    assign wr_en = Push & ~Full & ~Flush;
    assign rd_en = Pop & ~Empty;

    assign Pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= Push_data;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{DEPTH_LOG2{1'b0}}, wr_en};
            rd_ptr <= rd_ptr + {{DEPTH_LOG2{1'b0}}, rd_en};
        end
    end

endmodule

// File: rtl/uart_tx_byte_feeder.sv
// Buffers bytes from system producers and feeds them one at a time to the
// UART transmit controller through its Start/TX_data/Empty handshake.
module uart_tx_byte_feeder
    import uart_tx_byte_feeder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Push,
    input  logic [7:0]          Push_data,
    input  logic                Flush,
    output logic                Full,
    output logic [DEPTH_LOG2:0] Fill_count,
    output logic                Overflow,
    output logic                Busy,
    output logic                TX_start,
    output logic [7:0]          TX_data,
    input  logic                TX_empty
);

    tx_feeder_state_t  state;
    logic              fifo_empty;
    logic              pop;
    logic [BYTE_W-1:0] head;

    assign pop  = (state == S_FEED_IDLE) & ~fifo_empty & TX_empty;
    assign Busy = (Fill_count != '0) | (state != S_FEED_IDLE);

    uart_tx_sync_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Flush     (Flush),
        .Push      (Push),
        .Push_data (Push_data),
        .Pop       (pop),
        .Pop_data  (head),
        .Full      (Full),
        .Empty     (fifo_empty),
        .Count     (Fill_count)
    );

    // Full is judged before any pop, so a push on a full cycle is lost.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Overflow <= 1'b0;
        end else if (Flush) begin
            Overflow <= 1'b0;
        end else if (Push && Full) begin
            Overflow <= 1'b1;
        end
    end

    // WAIT is only reachable after Empty was seen low, so a stale high
    // Empty can never trigger a second send of the same byte.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_FEED_IDLE;
            TX_start <= 1'b0;
            TX_data  <= 8'h00;
        end else begin
            case (state)
                S_FEED_IDLE: begin
                    if (pop) begin
                        TX_data  <= head;
                        TX_start <= 1'b1;
                        state    <= S_FEED_REQ;
                    end else begin
                        TX_start <= 1'b0;
                    end
                end
                S_FEED_REQ: begin
                    if (!TX_empty) begin
                        TX_start <= 1'b0;
                        state    <= S_FEED_WAIT;
                    end
                end
                S_FEED_WAIT: begin
                    if (TX_empty) begin
                        state <= S_FEED_IDLE;
                    end
                end
                default: begin
                    state    <= S_FEED_IDLE;
                    TX_start <= 1'b0;
                end
            endcase
        end
    end

endmodule
